// File: rtl/requant_rr_sched_if.sv
// Stream bundle for the shared requantiser: N_CH request lanes in, one tagged int4 result out.
// master = upstream/downstream side, slave = the scheduler.
interface requant_rr_sched_if #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
);
    logic [N_CH-1:0]    in_valid;
    logic [N_CH*16-1:0] in_data;
    logic [N_CH-1:0]    in_ready;
    logic               out_valid;
    logic [3:0]         out_data;
    logic [CH_W-1:0]    out_ch;
    logic               out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/requant_rr_sched.sv
// Round-robin scheduler sharing one int16->int4 requantiser (arithmetic shift + saturation)
// across N_CH channels; a start-triggered frame FSM counts transfers up to cfg_len.
module requant_rr_sched #(
    parameter int N_CH  = 4,
    parameter int CH_W  = 2,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [3:0]        cfg_shift,
    output logic              busy,
    output logic              done,
    requant_rr_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_nx;
    logic [CH_W-1:0]    rr_ptr;
    logic [LEN_W-1:0]   count;
    logic [LEN_W-1:0]   len_q;
    logic [3:0]         shift_q;
    logic               out_valid_q;
    logic [3:0]         out_data_q;
    logic [CH_W-1:0]    out_ch_q;

    logic               found;
    logic [CH_W-1:0]    win;
    int                 idx;
    logic               out_free;
    logic               issue;
    logic               xfer;
    logic signed [15:0] sel_data;
    logic signed [15:0] shifted;
    logic [3:0]         sat_val;

    // Rotating priority search starting at rr_ptr, wrapping modulo N_CH.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
    end

    assign out_free = !out_valid_q || bus.out_ready;
    assign issue    = (state == RUN) && (count < len_q) && out_free;
    assign xfer     = issue && found;

    always_comb begin
        bus.in_ready = '0;
        if (xfer) bus.in_ready[win] = 1'b1;
    end

    // Saturation compares the whole 16-bit shifted value, not just the low nibble.
    always_comb begin
        sel_data = bus.in_data[16*int'(win) +: 16];
        shifted  = sel_data >>> shift_q;
        if (shifted > 16'sd7)
            sat_val = 4'b0111;
        else if (shifted < -16'sd8)
            sat_val = 4'b1000;
        else
            sat_val = shifted[3:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (cfg_len != '0) ? RUN : DONE;
            RUN:     if (xfer && (count + 1'b1 == len_q)) state_nx = DRAIN;
            DRAIN:   if (out_free) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            count       <= '0;
            len_q       <= '0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                len_q   <= cfg_len;
                shift_q <= cfg_shift;
                count   <= '0;
            end
            if (xfer) begin
                count       <= count + 1'b1;
                rr_ptr      <= (win == CH_W'(N_CH - 1)) ? '0 : win + 1'b1;
                out_valid_q <= 1'b1;
                out_data_q  <= sat_val;
                out_ch_q    <= win;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_requant_rr_sched.sv
// Directed bench for requant_rr_sched: expected results queued per frame, a monitor pops and
// compares on each output handshake.
module tb_requant_rr_sched;

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_len;
    logic [3:0]  cfg_shift;
    logic        busy;
    logic        done;

    requant_rr_sched_if #(.N_CH(4), .CH_W(2)) bus ();

    requant_rr_sched #(.N_CH(4), .CH_W(2), .LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_shift (cfg_shift),
        .busy      (busy),
        .done      (done),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   last_acc = -1;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int ch, input logic [3:0] d);
        exp_t e;
        e.ch   = 2'(ch);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic set_data(input logic [15:0] d0, d1, d2, d3);
        bus.in_data = {d3, d2, d1, d0};
    endtask

    // Monitor: sampled 1 time unit after the falling edge, i.e. the values seen by the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got ch %0d data %0h expected none", bus.out_ch, bus.out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_ch", 32'(bus.out_ch), 32'(e.ch));
                    check("out_data", 32'(bus.out_data), 32'(e.data));
                end
                last_acc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input logic [15:0] len, input logic [3:0] sh);
        @(negedge clk);
        start     = 1'b1;
        cfg_len   = len;
        cfg_shift = sh;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; checks busy, lane masking, done latency and pulse width.
    task automatic wait_done(input string name, input bit nonzero, input logic [3:0] allowed,
                             input bit restart);
        bit got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (restart && c == 0) begin
                start     = 1'b1;
                cfg_len   = 16'd5;
                cfg_shift = 4'd3;
            end else begin
                start = 1'b0;
            end
            #2;
            if (c == 0) check({name, "_busy"}, 32'(busy), 32'(nonzero));
            if (allowed != 4'hF) check({name, "_in_ready_mask"}, 32'(bus.in_ready & ~allowed), 32'h0);
            if (done) begin
                got = 1'b1;
                check({name, "_done_in_ready"}, 32'(bus.in_ready), 32'h0);
                if (nonzero) check({name, "_done_latency"}, 32'(cyc), 32'(last_acc + 1));
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
        end
        @(negedge clk);
        #2;
        check({name, "_done_pulse"}, 32'(done), 32'h0);
        check({name, "_idle"}, 32'(busy), 32'h0);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'h0);
        bus.in_valid = '0;
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        cfg_len       = '0;
        cfg_shift     = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        check("rst_out_ch", 32'(bus.out_ch), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);

        // 1: reset in the middle of a frame with a result held
        bus.in_valid = 4'hF;
        set_data(16'd1, 16'd2, 16'd3, 16'd4);
        start_frame(16'd4, 4'd0);
        @(negedge clk);
        #2;
        check("t1_out_valid_pre", 32'(bus.out_valid), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("t1_out_valid", 32'(bus.out_valid), 32'h0);
        check("t1_out_data", 32'(bus.out_data), 32'h0);
        check("t1_out_ch", 32'(bus.out_ch), 32'h0);
        check("t1_in_ready", 32'(bus.in_ready), 32'h0);
        check("t1_busy", 32'(busy), 32'h0);
        rst          = 1'b0;
        bus.in_valid = '0;

        // 2: all four lanes, shift 0, mixed saturation
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'hF;
        set_data(16'd3, -16'sd2, 16'd100, -16'sd300);
        push(0, 4'h3); push(1, 4'hE); push(2, 4'h7); push(3, 4'h8);
        start_frame(16'd4, 4'd0);
        wait_done("t2", 1'b1, 4'hF, 1'b0);

        // 3: shift 4 boundaries
        bus.in_valid = 4'hF;
        set_data(16'h0070, 16'h0080, 16'hFF80, 16'hFF90);
        push(0, 4'h7); push(1, 4'h7); push(2, 4'h8); push(3, 4'h9);
        start_frame(16'd4, 4'd4);
        wait_done("t3", 1'b1, 4'hF, 1'b0);

        // 4: only lanes 1 and 3 requesting
        bus.in_valid = 4'b1010;
        set_data(16'd0, 16'd1, 16'd0, -16'sd1);
        for (int i = 0; i < 3; i++) begin
            push(1, 4'h1);
            push(3, 4'hF);
        end
        start_frame(16'd6, 4'd0);
        wait_done("t4", 1'b1, 4'b1010, 1'b0);

        // 5: downstream stall holds the output register and blocks issue
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'hF;
        set_data(16'd5, 16'd6, -16'sd5, 16'd0);
        push(0, 4'h5); push(1, 4'h6); push(2, 4'hB);
        start_frame(16'd3, 4'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #2;
            check("t5_stall_valid", 32'(bus.out_valid), 32'h1);
            check("t5_stall_data", 32'(bus.out_data), 32'h5);
            check("t5_stall_ch", 32'(bus.out_ch), 32'h0);
            check("t5_stall_in_ready", 32'(bus.in_ready), 32'h0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        wait_done("t5", 1'b1, 4'hF, 1'b0);

        // 6: zero-length frame, then a start during RUN that must be ignored
        bus.in_valid = 4'hF;
        start_frame(16'd0, 4'd0);
        wait_done("t6_zero", 1'b0, 4'hF, 1'b0);
        bus.in_valid = 4'hF;
        set_data(16'd2, 16'd0, 16'd0, -16'sd9);
        push(3, 4'h8); push(0, 4'h2);
        start_frame(16'd2, 4'd0);
        wait_done("t6_ign", 1'b1, 4'hF, 1'b1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
